system: RTL and testbench
=========================

SYSTEM -- requirements
Module: system

Interface
REQ-001 The block SHALL have parameter clk_freq, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter uart_baud_rate, default 115200, meaning the UART bit rate in bit/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port led, output, 1 bit: a toggle indicator for received bytes.
REQ-006 The block SHALL have port ps2_clk, inout, 1 bit: the PS/2 clock line from the device; open-drain; the block never drives it (constant high-Z).
REQ-007 The block SHALL have port ps2_data, inout, 1 bit: the PS/2 data line; open-drain; the block never drives it (constant high-Z).
REQ-008 The block SHALL have port uart_rxd, input, 1 bit: reserved; it is ignored.
REQ-009 The block SHALL have port uart_txd, output, 1 bit: serial output, 8N1, idle high.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-011 ps2_clk SHALL then be debounced: the filtered value changes only after 8 consecutive identical synchronized samples.
REQ-012 A PS/2 bit SHALL be sampled from synchronized ps2_data on each filtered ps2_clk falling edge.
REQ-013 The frame SHALL be 11 bits in this order: start (0), d0..d7 LSB first, odd parity, stop (1).
REQ-014 Receiver states SHALL be IDLE, SHIFT and CHECK.
REQ-015 The IDLE state SHALL move to SHIFT on a falling edge with data=0.
REQ-016 A falling edge in IDLE with data=1 SHALL be ignored (the block stays in IDLE).
REQ-017 The SHIFT state SHALL count 10 further edges, then go to CHECK.
REQ-018 The CHECK state SHALL accept the frame when the parity is odd over d0..d7 plus the parity bit AND stop=1, then return to IDLE in one cycle.
REQ-019 A rejected frame SHALL be silently discarded.
REQ-020 Mid-frame timeout: if no falling edge occurs for clk_freq/10000 cycles (100 us) while in SHIFT, the receiver SHALL return to IDLE and discard the partial frame.
REQ-021 When a frame is accepted, the byte SHALL load into a 1-entry holding register and led SHALL toggle.
REQ-022 The holding register SHALL behave as follows:
- It is empty after reset.
- When it is full and another frame is accepted, the new byte overwrites it (last wins).
- led still toggles on that overwrite.
REQ-023 The UART TX SHALL operate as follows:
- Divisor = clk_freq/uart_baud_rate, integer floor.
- Each bit lasts exactly divisor clk cycles.
- Bit order: start 0, d0..d7, stop 1.
REQ-024 The UART TX SHALL take a byte from the holding register when the TX is idle and the register is full.
REQ-025 uart_txd SHALL fall to the start bit 1 clk cycle after the holding register becomes full.
REQ-026 If the take of a byte and an accept occur in the same cycle, the register SHALL stay full with the new byte.
REQ-027 Back-to-back UART frames SHALL have no gap beyond the stop bit.

Reset
REQ-028 While rst=0, the outputs SHALL be: led=0, uart_txd=1, ps2 lines high-Z.
REQ-029 While rst=0, the receiver SHALL be in IDLE, the bit counter and timeout counter 0, the holding register empty, and the TX idle.
REQ-030 Reset asserted mid-frame or mid-UART-byte SHALL abort immediately; no partial byte is emitted after release.
REQ-031 After release, the block SHALL ignore ps2 edges until the filtered ps2_clk has been high once.

Structure
REQ-032 The shared package SHALL hold:
- the receiver state enum (IDLE/SHIFT/CHECK);
- PS2_FRAME_BITS=11;
- the debounce length 8;
- the timeout function of clk_freq.
REQ-033 The UART transmitter SHALL be one sub-module, uart_tx.
REQ-034 uart_tx SHALL take parameters clk_freq and uart_baud_rate and have ports clk, rst, data[7:0], valid, busy and txd.
REQ-035 The PS/2 receive logic SHALL reside in system.

Verification
REQ-036 Test conditions: clk_freq=50000000, uart_baud_rate=1152000, divisor 43, PS/2 clock period 20 us; data changes only while ps2_clk is high.
REQ-037 Scenario: PS/2 frame 0x1C with parity 0 -> uart_txd shows 0,0,0,1,1,1,0,0,0,1 at 43 cycles per bit, and led goes 0->1.
REQ-038 Scenario: 0x1C with parity 1 (error) -> uart_txd stays 1 and led unchanged; then a valid 0xF0 -> 0xF0 sent.
REQ-039 Scenario: start bit plus 4 data bits, then 200 us idle, then a valid 0x5A -> only 0x5A sent.
REQ-040 Scenario: stop bit 0 on 0x1C -> no UART output.
REQ-041 Scenario: rst=0 after 6 PS/2 bits, released, then a valid 0x29 -> only 0x29 sent, and led=1 after that byte.
REQ-042 Scenario: ps2_clk toggling with ps2_data high (no start bit) -> no output, and the ps2 lines are never driven by the block.

Source files
------------

// File: rtl/system_pkg.sv
// Shared types, constants and helpers for the PS/2-to-UART bridge.
package system_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int DEBOUNCE_LEN   = 8;

  // Mid-frame silence limit of 100 us expressed in clk cycles.
  function automatic int timeout_cycles(input int clk_freq);
    return clk_freq / 10000;
  endfunction

  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/system_if.sv
// Observation bundle for the bridge's UART and indicator pins.
interface system_if;
  logic led;
  logic uart_txd;
  logic uart_rxd;

  modport master (output uart_rxd, input led, input uart_txd);
  modport slave  (input uart_rxd, output led, output uart_txd);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; busy drops in the last stop-bit cycle so frames can abut.
module uart_tx
  import system_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       busy,
  output logic       txd
);

  localparam int DIV   = clk_freq / uart_baud_rate;
  localparam int CNT_W = $clog2(DIV + 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [8:0]       sh_q, sh_d;
  logic             txd_q, txd_d;
  logic             last_s, load_s, bit_end_s;

  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    txd_d     = txd_q;
    bit_end_s = (cnt_q == CNT_W'(DIV - 1));
    last_s    = active_q && (idx_q == 4'd9) && bit_end_s;
    busy      = active_q && !last_s;
    load_s    = valid && !busy;
    if (load_s) begin
      active_d = 1'b1;
      cnt_d    = '0;
      idx_d    = 4'd0;
      sh_d     = {1'b1, data};
      txd_d    = 1'b0;
    end else if (last_s) begin
      active_d = 1'b0;
      cnt_d    = '0;
      idx_d    = 4'd0;
      txd_d    = 1'b1;
    end else if (active_q) begin
      if (bit_end_s) begin
        cnt_d = '0;
        idx_d = idx_q + 4'd1;
        txd_d = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      sh_q     <= 9'h1FF;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/system.sv
// PS/2 device receiver feeding a one-byte holding register that is drained by a UART.
module system
  import system_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  inout  wire  ps2_clk,
  inout  wire  ps2_data,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int TMO   = timeout_cycles(clk_freq);
  localparam int TMO_W = $clog2(TMO + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_LEN);

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  logic unused_rxd_s;
  assign unused_rxd_s = uart_rxd;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  rx_state_e        state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic             led_q, led_d;
  logic             fall_s, accept_s, take_s, tx_busy_s;

  // Filtered clock resets low, so no edge is seen until the line has read high once.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    fall_s = filt_q && !filt_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    accept_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
        if (fall_s && !data_sync_q[1]) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (fall_s) begin
          shift_d   = {data_sync_q[1], shift_q[9:1]};
          tmo_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (tmo_q == TMO_W'(TMO - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        accept_s = odd_parity_ok(shift_q[8:0]) && shift_q[9];
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new byte always wins, even when the UART takes the old one in the same cycle.
  always_comb begin
    take_s = full_q && !tx_busy_s;
    if (accept_s) begin
      hold_d = shift_q[7:0];
      full_d = 1'b1;
      led_d  = !led_q;
    end else begin
      hold_d = hold_q;
      full_d = full_q && !take_s;
      led_d  = led_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b00;
      data_sync_q <= 2'b00;
      filt_q      <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      tmo_q       <= '0;
      shift_q     <= 10'd0;
      hold_q      <= 8'd0;
      full_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

  uart_tx #(
    .clk_freq       (clk_freq),
    .uart_baud_rate (uart_baud_rate)
  ) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (hold_q),
    .valid (full_q),
    .busy  (tx_busy_s),
    .txd   (uart_txd)
  );

endmodule

// File: tb/tb_system.sv
// Bench for the PS/2-to-UART bridge: frame table plus reset/timeout sequences, UART scoreboard.
`timescale 1ns/1ps
module tb_system;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 1152000;
  localparam int DIV      = 43;
  localparam int PS2_Q    = 250;
  localparam int PS2_H    = 500;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk_drv, ps2_data_drv;
  wire  ps2_clk_w, ps2_data_w;

  always #10 clk = ~clk;

  assign ps2_clk_w  = ps2_clk_drv;
  assign ps2_data_w = ps2_data_drv;

  system_if sif ();

  system #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .led      (sif.led),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w),
    .uart_rxd (sif.uart_rxd),
    .uart_txd (sif.uart_txd)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       led_exp;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       good;
  } vec_t;
  vec_t vecs[4];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_drv = b;
    repeat (PS2_Q) @(negedge clk);
    ps2_clk_drv = 1'b0;
    repeat (PS2_H) @(negedge clk);
    ps2_clk_drv = 1'b1;
    repeat (PS2_Q) @(negedge clk);
  endtask

  task automatic ps2_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data_drv = 1'b1;
  endtask

  // UART monitor: every bit must hold for exactly DIV cycles; bytes are matched against the queue.
  initial begin : uart_mon
    logic [9:0] bits;
    logic       stable;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sif.uart_txd === 1'b0) begin
        stable = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[b] = sif.uart_txd;
            else if (sif.uart_txd !== bits[b]) stable = 1'b0;
          end
        end
        checks++;
        if (!stable || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
          errors++;
          $display("FAIL uart_frame: bits(lsb=start) %b steady %0d, required 43-cycle bits, start 0, stop 1", bits, stable);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uart_byte: got unexpected 0x%02h, required no output", bits[8:1]);
        end else begin
          exp = exp_q.pop_front();
          if (bits[8:1] !== exp) begin
            errors++;
            $display("FAIL uart_byte: got 0x%02h, required 0x%02h", bits[8:1], exp);
          end
        end
      end
    end
  end

  initial begin
    vecs[0] = '{data: 8'h1C, par_flip: 1'b0, stop: 1'b1, good: 1'b1};
    vecs[1] = '{data: 8'h1C, par_flip: 1'b1, stop: 1'b1, good: 1'b0};
    vecs[2] = '{data: 8'hF0, par_flip: 1'b0, stop: 1'b1, good: 1'b1};
    vecs[3] = '{data: 8'h1C, par_flip: 1'b0, stop: 1'b0, good: 1'b0};

    rst_n        = 1'b0;
    ps2_clk_drv  = 1'b1;
    ps2_data_drv = 1'b1;
    sif.uart_rxd = 1'b0;
    led_exp      = 1'b0;
    repeat (5) @(negedge clk);
    check1("reset_led", 32'(sif.led), 32'd0);
    check1("reset_txd", 32'(sif.uart_txd), 32'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].good) begin
        exp_q.push_back(vecs[i].data);
        led_exp = !led_exp;
      end
      ps2_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, 11);
      check1($sformatf("led_after_vec%0d", i), 32'(sif.led), 32'(led_exp));
    end

    // Start plus four data bits, then silence long enough to time out.
    ps2_frame(8'hA5, 1'b0, 1'b1, 5);
    repeat (10000) @(negedge clk);
    exp_q.push_back(8'h5A);
    led_exp = !led_exp;
    ps2_frame(8'h5A, 1'b0, 1'b1, 11);
    check1("led_after_5a", 32'(sif.led), 32'(led_exp));

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check1("drain_before_reset", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame.
    ps2_frame(8'h29, 1'b0, 1'b1, 6);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check1("midframe_reset_led", 32'(sif.led), 32'd0);
    check1("midframe_reset_txd", 32'(sif.uart_txd), 32'd1);
    exp_q.delete();
    led_exp = 1'b0;
    rst_n   = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h29);
    led_exp = 1'b1;
    ps2_frame(8'h29, 1'b0, 1'b1, 11);
    check1("led_after_29", 32'(sif.led), 32'(led_exp));

    // Clock activity with data held high: no start bit, lines stay as the device drives them.
    ps2_data_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (PS2_Q) @(negedge clk);
      ps2_clk_drv = 1'b0;
      repeat (PS2_Q) @(negedge clk);
      check1("ps2_clk_line_low", 32'(ps2_clk_w), 32'd0);
      check1("ps2_data_line_high", 32'(ps2_data_w), 32'd1);
      ps2_clk_drv = 1'b1;
      repeat (PS2_Q) @(negedge clk);
    end
    check1("ps2_clk_line_high", 32'(ps2_clk_w), 32'd1);

    repeat (600) @(negedge clk);
    check1("led_final", 32'(sif.led), 32'(led_exp));
    check1("missing_uart_bytes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
